// File: rtl/systolic_drain.sv
// ---------------------------------------------------------------------------
// systolic_drain
//
// Read-out end of a TILE x TILE systolic array tile. After the edge feeder
// starts a matrix pass (START), the block waits out the fixed skew/compute
// latency, snapshots every PE accumulator in a single cycle, pulses ACC_CLR
// so the array can begin the next pass, and then streams the snapshot out
// in row-major order over a valid/ready handshake.
//
// Ports
//   CLK        : single clock, rising edge
//   RSTN       : synchronous active-low reset
//   EN         : global enable; low freezes all state and masks ACC_CLR
//   START      : one-cycle pulse with the first skewed edge word
//   ACC        : flattened accumulators, PE(r,c) at [(r*TILE+c)*ACC_W +: ACC_W]
//   ACC_CLR    : one-cycle pulse telling the array to zero its accumulators
//   BUSY       : high from accepted START until the last word is transferred
//   OUT_VALID  : result word available
//   OUT_READY  : consumer accepts the word on this edge
//   OUT_DATA   : result value
//   OUT_IDX    : row-major index r*TILE+c of OUT_DATA
//   OUT_LAST   : high with the final word of a pass
//   OVERRUN    : sticky, set when START arrives while BUSY
// ---------------------------------------------------------------------------
module systolic_drain #(
   parameter int TILE    = 2,
   parameter int ACC_W   = 32,
   parameter int LATENCY = 4,
   localparam int N      = TILE * TILE,
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  EN,
   input  logic                  START,
   input  logic [N*ACC_W-1:0]    ACC,
   output logic                  ACC_CLR,
   output logic                  BUSY,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [ACC_W-1:0]      OUT_DATA,
   output logic [IDX_W-1:0]      OUT_IDX,
   output logic                  OUT_LAST,
   output logic                  OVERRUN
);

   // The wait counter only ever holds values 0..LATENCY-1.
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_CAPTURE,
      ST_STREAM
   } state_t;

   state_t             state_q,     state_d;
   logic [CNT_W-1:0]   cnt_q,       cnt_d;
   logic               busy_q,      busy_d;
   logic               acc_clr_q,   acc_clr_d;
   logic               out_valid_q, out_valid_d;
   logic [ACC_W-1:0]   out_data_q,  out_data_d;
   logic [IDX_W-1:0]   out_idx_q,   out_idx_d;
   logic               out_last_q,  out_last_d;
   logic               overrun_q,   overrun_d;
   logic [ACC_W-1:0]   snap_q [N];
   logic [ACC_W-1:0]   snap_d [N];

   logic               handshake;
   logic               last_hs;
   logic [IDX_W-1:0]   next_idx;

   // Next-state logic. Everything defaults to holding its value so that
   // EN low freezes the whole block, including a pending ACC_CLR pulse,
   // which then completes once EN returns. A START coinciding with the
   // final handshake is a legal back-to-back pass rather than an overrun.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      busy_d      = busy_q;
      acc_clr_d   = acc_clr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      overrun_d   = overrun_q;
      for (int i = 0; i < N; i++) begin
         snap_d[i] = snap_q[i];
      end

      handshake = out_valid_q & OUT_READY;
      last_hs   = (state_q == ST_STREAM) && handshake && (out_idx_q == IDX_W'(N - 1));
      next_idx  = out_idx_q + IDX_W'(1);

      if (EN) begin
         acc_clr_d = 1'b0;

         if (START && busy_q && !last_hs) begin
            overrun_d = 1'b1;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (START) begin
                  state_d = ST_WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
                  busy_d  = 1'b1;
               end
            end

            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_d   = ST_CAPTURE;
                  acc_clr_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end

            // The snapshot and the array clear share this edge, so the
            // snapshot sees the fully accumulated pre-clear values.
            ST_CAPTURE: begin
               for (int i = 0; i < N; i++) begin
                  snap_d[i] = ACC[i*ACC_W +: ACC_W];
               end
               out_data_d  = ACC[0 +: ACC_W];
               out_idx_d   = '0;
               out_last_d  = (N == 1);
               out_valid_d = 1'b1;
               state_d     = ST_STREAM;
            end

            ST_STREAM: begin
               if (handshake) begin
                  if (last_hs) begin
                     out_valid_d = 1'b0;
                     out_last_d  = 1'b0;
                     if (START) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                        busy_d  = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                     end
                  end else begin
                     out_idx_d  = next_idx;
                     out_data_d = snap_q[next_idx];
                     out_last_d = (next_idx == IDX_W'(N - 1));
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // All state, including the registered outputs, lives in this one block.
   // Reset abandons any pass in flight without issuing ACC_CLR.
   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         busy_q      <= 1'b0;
         acc_clr_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            snap_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         busy_q      <= busy_d;
         acc_clr_q   <= acc_clr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         overrun_q   <= overrun_d;
         for (int i = 0; i < N; i++) begin
            snap_q[i] <= snap_d[i];
         end
      end
   end

   // ACC_CLR is masked by EN so the array never sees a clear while frozen.
   assign ACC_CLR   = acc_clr_q & EN;
   assign BUSY      = busy_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_DATA  = out_data_q;
   assign OUT_IDX   = out_idx_q;
   assign OUT_LAST  = out_last_q;
   assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_systolic_drain.sv
// ---------------------------------------------------------------------------
// tb_systolic_drain
//
// Self-checking bench for systolic_drain (TILE=2, ACC_W=32, LATENCY=4).
// A small behavioural 2x2 systolic array produces ACC from skewed edge
// feeds and honours ACC_CLR. Expected result words are hand-computed
// matrix products pushed into a scoreboard queue when START is issued; a
// monitor pops and compares on every handshake. Cycle-level timing of
// BUSY, ACC_CLR, OUT_VALID and OVERRUN is checked directly by the stimulus.
// ---------------------------------------------------------------------------
module tb_systolic_drain;

   localparam int TILE    = 2;
   localparam int ACC_W   = 32;
   localparam int LATENCY = 4;
   localparam int N       = TILE * TILE;
   localparam int IDX_W   = 2;

   logic               CLK = 1'b0;
   logic               RSTN;
   logic               EN;
   logic               START;
   logic [N*ACC_W-1:0] ACC;
   logic               ACC_CLR;
   logic               BUSY;
   logic               OUT_VALID;
   logic               OUT_READY;
   logic [ACC_W-1:0]   OUT_DATA;
   logic [IDX_W-1:0]   OUT_IDX;
   logic               OUT_LAST;
   logic               OVERRUN;

   typedef struct {
      logic [ACC_W-1:0] data;
      int               idx;
      logic             last;
   } exp_t;

   exp_t exp_q [$];

   int num_checks = 0;
   int num_errors = 0;
   int clr_count  = 0;

   // Two operand sets. Set 0: A=[[1,2],[3,4]], B=[[5,6],[7,8]].
   // Set 1: A=[[2,0],[1,1]], B=[[1,1],[3,2]]. Indexed [set][step][row/col].
   int west_tab  [2][3][2] = '{ '{ '{1,0}, '{2,3}, '{0,4} },
                                '{ '{2,0}, '{0,1}, '{0,1} } };
   int north_tab [2][3][2] = '{ '{ '{5,0}, '{7,6}, '{0,8} },
                                '{ '{1,0}, '{3,1}, '{0,2} } };
   int exp_tab   [2][4]    = '{ '{19, 22, 43, 50},
                                '{ 2,  2,  4,  3} };

   logic [ACC_W-1:0] west  [TILE];
   logic [ACC_W-1:0] north [TILE];
   logic [ACC_W-1:0] a_m   [TILE][TILE];
   logic [ACC_W-1:0] b_m   [TILE][TILE];
   logic [ACC_W-1:0] acc_m [TILE][TILE];
   logic [ACC_W-1:0] a_in  [TILE][TILE];
   logic [ACC_W-1:0] b_in  [TILE][TILE];

   systolic_drain #(
      .TILE    (TILE),
      .ACC_W   (ACC_W),
      .LATENCY (LATENCY)
   ) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .EN        (EN),
      .START     (START),
      .ACC       (ACC),
      .ACC_CLR   (ACC_CLR),
      .BUSY      (BUSY),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_DATA  (OUT_DATA),
      .OUT_IDX   (OUT_IDX),
      .OUT_LAST  (OUT_LAST),
      .OVERRUN   (OVERRUN)
   );

   // Free-running clock, 10 time units per period.
   always #5 CLK = ~CLK;

   // PE operand routing: a flows east from the west edge, b flows south
   // from the north edge, each through one register per PE.
   always_comb begin
      for (int r = 0; r < TILE; r++) begin
         for (int c = 0; c < TILE; c++) begin
            a_in[r][c] = '0;
            b_in[r][c] = '0;
            if (c == 0) a_in[r][c] = west[r];
            else        a_in[r][c] = a_m[r][c-1];
            if (r == 0) b_in[r][c] = north[c];
            else        b_in[r][c] = b_m[r-1][c];
         end
      end
   end

   // Behavioural array: multiply-accumulate each edge, cleared by ACC_CLR
   // and by the shared reset.
   always @(posedge CLK) begin
      for (int r = 0; r < TILE; r++) begin
         for (int c = 0; c < TILE; c++) begin
            if (!RSTN) begin
               a_m[r][c]   <= '0;
               b_m[r][c]   <= '0;
               acc_m[r][c] <= '0;
            end else begin
               a_m[r][c]   <= a_in[r][c];
               b_m[r][c]   <= b_in[r][c];
               acc_m[r][c] <= ACC_CLR ? '0 : acc_m[r][c] + a_in[r][c] * b_in[r][c];
            end
         end
      end
   end

   // Flatten the accumulators into the DUT's ACC bus.
   always_comb begin
      ACC = '0;
      for (int r = 0; r < TILE; r++) begin
         for (int c = 0; c < TILE; c++) begin
            ACC[(r*TILE+c)*ACC_W +: ACC_W] = acc_m[r][c];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [ACC_W-1:0] actual,
                              input logic [ACC_W-1:0] expected);
      num_checks++;
      if (actual !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drive one step of a skewed feed (zeros past the end) and START.
   task automatic applyStimulus(input int set, input int step, input logic start);
      START = start;
      for (int i = 0; i < TILE; i++) begin
         if (step < 3) begin
            west[i]  = ACC_W'(west_tab[set][step][i]);
            north[i] = ACC_W'(north_tab[set][step][i]);
         end else begin
            west[i]  = '0;
            north[i] = '0;
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_set(input int set);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.data = ACC_W'(exp_tab[set][i]);
         e.idx  = i;
         e.last = (i == N - 1);
         exp_q.push_back(e);
      end
   endtask

   // Keep feeding and clocking until BUSY drops, optionally toggling
   // OUT_READY with the 1,0,0,1 pattern; bounded so it cannot hang.
   task automatic wait_idle(input int set, input int step0, input logic toggle);
      int n;
      n = 0;
      while (BUSY && n < 64) begin
         applyStimulus(set, step0 + n, 1'b0);
         if (toggle) OUT_READY = ((n % 4) == 0) || ((n % 4) == 3);
         tick();
         n++;
      end
      num_checks++;
      if (BUSY) begin
         num_errors++;
         $display("[TB] FAIL wait_idle: BUSY still 1 after %0d cycles, expected 0", n);
      end
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active
   // edge. Pops one expected word per handshake and checks that outputs
   // held still across every stalled cycle.
   initial begin
      exp_t             e;
      logic             prev_stall;
      logic [ACC_W-1:0] prev_data;
      logic [IDX_W-1:0] prev_idx;
      logic             prev_last;
      prev_stall = 1'b0;
      prev_data  = '0;
      prev_idx   = '0;
      prev_last  = 1'b0;
      forever begin
         @(negedge CLK);
         if (ACC_CLR === 1'b1) clr_count++;
         if (prev_stall) begin
            checkOutput("stall_data", OUT_DATA, prev_data);
            checkOutput("stall_idx", ACC_W'(OUT_IDX), ACC_W'(prev_idx));
            checkOutput("stall_last", ACC_W'(OUT_LAST), ACC_W'(prev_last));
         end
         if (RSTN && EN && OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               num_checks++;
               num_errors++;
               $display("[TB] FAIL sb_unexpected: got word %0d idx %0d, expected none", OUT_DATA, OUT_IDX);
            end else begin
               e = exp_q.pop_front();
               checkOutput("sb_data", OUT_DATA, e.data);
               checkOutput("sb_idx", ACC_W'(OUT_IDX), ACC_W'(e.idx));
               checkOutput("sb_last", ACC_W'(OUT_LAST), ACC_W'(e.last));
            end
         end
         prev_stall = RSTN && OUT_VALID && (!OUT_READY || !EN);
         prev_data  = OUT_DATA;
         prev_idx   = OUT_IDX;
         prev_last  = OUT_LAST;
      end
   end

   // Hard stop in case anything wedges the main sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed sequence.
   initial begin
      int c0;
      RSTN      = 1'b0;
      EN        = 1'b1;
      OUT_READY = 1'b1;
      applyStimulus(0, 3, 1'b0);
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("rst_busy", ACC_W'(BUSY), 0);
      checkOutput("rst_valid", ACC_W'(OUT_VALID), 0);
      checkOutput("rst_last", ACC_W'(OUT_LAST), 0);
      checkOutput("rst_clr", ACC_W'(ACC_CLR), 0);
      checkOutput("rst_overrun", ACC_W'(OVERRUN), 0);
      checkOutput("rst_data", OUT_DATA, 0);
      checkOutput("rst_idx", ACC_W'(OUT_IDX), 0);
      RSTN = 1'b1;
      tick();

      $display("[TB] basic pass with cycle timing");
      push_set(0);
      applyStimulus(0, 0, 1'b1);
      tick();
      c0 = clr_count;
      for (int k = 0; k <= 9; k++) begin
         checkOutput("t1_busy", ACC_W'(BUSY), ACC_W'(k <= 8));
         checkOutput("t1_clr", ACC_W'(ACC_CLR), ACC_W'(k == 4));
         checkOutput("t1_valid", ACC_W'(OUT_VALID), ACC_W'(k >= 5 && k <= 8));
         applyStimulus(0, k + 1, 1'b0);
         tick();
      end
      checkOutput("t1_clr_count", ACC_W'(clr_count - c0), 1);

      $display("[TB] backpressure pass");
      push_set(0);
      applyStimulus(0, 0, 1'b1);
      tick();
      wait_idle(0, 1, 1'b1);
      OUT_READY = 1'b1;
      tick();

      $display("[TB] back-to-back passes");
      push_set(0);
      applyStimulus(0, 0, 1'b1);
      tick();
      for (int k = 0; k <= 7; k++) begin
         applyStimulus(0, k + 1, 1'b0);
         tick();
      end
      checkOutput("b2b_last_word", ACC_W'(OUT_LAST), 1);
      push_set(1);
      applyStimulus(1, 0, 1'b1);
      tick();
      checkOutput("b2b_busy", ACC_W'(BUSY), 1);
      checkOutput("b2b_overrun", ACC_W'(OVERRUN), 0);
      checkOutput("b2b_valid", ACC_W'(OUT_VALID), 0);
      wait_idle(1, 1, 1'b0);
      tick();

      $display("[TB] START while busy");
      push_set(0);
      applyStimulus(0, 0, 1'b1);
      tick();
      for (int k = 0; k <= 9; k++) begin
         checkOutput("ovr_flag", ACC_W'(OVERRUN), ACC_W'(k >= 2));
         checkOutput("ovr_busy", ACC_W'(BUSY), ACC_W'(k <= 8));
         applyStimulus(0, k + 1, (k == 1) || (k == 6));
         tick();
      end

      $display("[TB] reset mid-pass");
      applyStimulus(0, 0, 1'b1);
      tick();
      applyStimulus(0, 1, 1'b0);
      tick();
      RSTN = 1'b0;
      applyStimulus(0, 2, 1'b0);
      c0 = clr_count;
      tick();
      checkOutput("mid_rst_busy", ACC_W'(BUSY), 0);
      checkOutput("mid_rst_valid", ACC_W'(OUT_VALID), 0);
      checkOutput("mid_rst_last", ACC_W'(OUT_LAST), 0);
      checkOutput("mid_rst_clr", ACC_W'(ACC_CLR), 0);
      checkOutput("mid_rst_overrun", ACC_W'(OVERRUN), 0);
      checkOutput("mid_rst_data", OUT_DATA, 0);
      checkOutput("mid_rst_idx", ACC_W'(OUT_IDX), 0);
      RSTN = 1'b1;
      applyStimulus(0, 3, 1'b0);
      repeat (8) tick();
      checkOutput("mid_rst_no_clr", ACC_W'(clr_count - c0), 0);
      checkOutput("mid_rst_idle", ACC_W'(BUSY), 0);
      push_set(1);
      applyStimulus(1, 0, 1'b1);
      tick();
      wait_idle(1, 1, 1'b0);
      tick();

      $display("[TB] enable stall during wait");
      push_set(0);
      applyStimulus(0, 0, 1'b1);
      tick();
      c0 = clr_count;
      for (int k = 0; k <= 9; k++) begin
         if (k == 1) EN = 1'b0;
         if (k == 4) EN = 1'b1;
         checkOutput("en_clr", ACC_W'(ACC_CLR), ACC_W'(k == 7));
         checkOutput("en_valid", ACC_W'(OUT_VALID), ACC_W'(k >= 8));
         applyStimulus(0, k + 1, 1'b0);
         tick();
      end
      checkOutput("en_clr_count", ACC_W'(clr_count - c0), 1);
      wait_idle(0, 11, 1'b0);
      tick();

      checkOutput("sb_drained", ACC_W'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
